// File: rtl/conv_pkg.sv
// conv_pkg: shared sizes and FSM state type for the convolution stream adapter
package conv_pkg;
  localparam int DATA_W = 8;
  localparam int ROWS = 9;
  localparam int COLS = 9;
  localparam int NPIX = ROWS * COLS;
  localparam int MAT_W = DATA_W * NPIX;
  localparam int CNT_W = $clog2(NPIX);
  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;
endpackage

// File: rtl/conv_pix_counter.sv
// conv_pix_counter: 0..NPIX-1 pixel index with enable, sync clear and last-pixel flag
module conv_pix_counter
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] idx,
  output logic             at_last
);
  assign at_last = idx == CNT_W'(NPIX - 1);
  always_ff @(posedge clk)
    if (rst || clr) idx <= '0;
    else if (en) idx <= at_last ? '0 : idx + 1'b1;
endmodule

// File: rtl/conv_stream_adapter.sv
// conv_stream_adapter: packs a pixel stream into the core input matrix, starts the core,
// waits for done and streams the captured result matrix back out
module conv_stream_adapter
  import conv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic              conv_start,
  output logic [MAT_W-1:0]  conv_input_matrix,
  input  logic              conv_done,
  input  logic [MAT_W-1:0]  conv_output_matrix,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              err_framing,
  output logic              err_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t           state, state_d;
  logic [CNT_W-1:0] idx;
  logic             at_last;
  logic [TW-1:0]    wait_cnt;
  logic [MAT_W-1:0] out_mat;
  logic             s_fire, m_fire, timeout;
  assign s_ready    = state == LOAD;
  assign s_fire     = s_valid && s_ready;
  assign m_valid    = state == UNLOAD;
  assign m_fire     = m_valid && m_ready;
  assign m_data     = out_mat[DATA_W*int'(idx) +: DATA_W];
  assign m_last     = m_valid && at_last;
  assign conv_start = state == START;
  assign busy       = state != LOAD || idx != '0;
  // done takes priority over an expiring wait
  assign timeout    = state == WAIT && !conv_done && wait_cnt == TW'(TIMEOUT_CYCLES - 1);

  conv_pix_counter u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (timeout),
    .en      (s_fire || m_fire),
    .idx     (idx),
    .at_last (at_last)
  );

  always_comb begin
    state_d = state;
    case (state)
      LOAD:    if (s_fire && at_last) state_d = START;
      START:   state_d = WAIT;
      WAIT:    state_d = conv_done ? UNLOAD : timeout ? LOAD : WAIT;
      UNLOAD:  if (m_fire && at_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= LOAD;
      wait_cnt          <= '0;
      conv_input_matrix <= '0;
      out_mat           <= '0;
      err_framing       <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
      if (s_fire) begin
        conv_input_matrix[DATA_W*int'(idx) +: DATA_W] <= s_data;
        if (s_last != at_last) err_framing <= 1'b1;
      end
      if (state == WAIT && conv_done) out_mat <= conv_output_matrix;
      if (timeout) err_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_stream_adapter.sv
// tb_conv_stream_adapter: directed frame table plus timeout and mid-unload reset sequences
module tb_conv_stream_adapter;
  import conv_pkg::*;
  localparam int TO = 100;
  logic              clk = 1'b0, rst = 1'b1;
  logic [DATA_W-1:0] s_data = '0, m_data;
  logic              s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic              conv_start, conv_done = 1'b0;
  logic [MAT_W-1:0]  conv_input_matrix, conv_output_matrix = '0;
  logic              m_valid, m_ready = 1'b0, m_last, busy, err_framing, err_timeout;
  int                checks = 0, errors = 0;
  int                core_mode = 0, core_add = 0;
  logic [DATA_W-1:0] pix_q[NPIX];
  logic [DATA_W-1:0] exp_q[NPIX];

  typedef struct {
    int base, step, add, last_at;
    bit bp, gaps;
    int mode;
    bit exp_fr;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  conv_stream_adapter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .conv_start(conv_start), .conv_input_matrix(conv_input_matrix), .conv_done(conv_done),
    .conv_output_matrix(conv_output_matrix), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .err_framing(err_framing), .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] add_mat(input logic [MAT_W-1:0] m, input int a);
    logic [MAT_W-1:0] r;
    for (int k = 0; k < NPIX; k++) r[k*DATA_W +: DATA_W] = m[k*DATA_W +: DATA_W] + DATA_W'(a);
    return r;
  endfunction

  // core model: mode 0 answers after 20 cycles, 1 never answers, 2 holds done high in START
  always begin
    @(negedge clk);
    if (conv_start && core_mode != 1) begin
      if (core_mode == 2) begin
        conv_output_matrix = {NPIX{8'hAA}};
        conv_done = 1'b1;
        @(negedge clk);
      end else repeat (20) @(negedge clk);
      conv_output_matrix = add_mat(conv_input_matrix, core_add);
      conv_done = 1'b1;
      @(negedge clk);
      conv_done = 1'b0;
      chk("first_out_valid", m_valid, 1);
      chk("first_out_data", m_data, exp_q[0]);
    end
  end

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; conv_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_frame(input int base, input int step, input int add);
    for (int k = 0; k < NPIX; k++) begin
      pix_q[k] = DATA_W'(base + step * k);
      exp_q[k] = DATA_W'(pix_q[k] + DATA_W'(add));
    end
    core_add = add;
  endtask

  task automatic load_frame(input int last_at, input bit gaps);
    logic [MAT_W-1:0] exp_in;
    for (int k = 0; k < NPIX; k++) begin
      exp_in[k*DATA_W +: DATA_W] = pix_q[k];
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      s_valid = 1'b1; s_data = pix_q[k]; s_last = k == last_at;
      chk("s_ready_load", s_ready, 1);
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
    end
    chk("conv_start_after_last", conv_start, 1);
    chk("input_matrix", conv_input_matrix, exp_in);
    @(negedge clk);
    chk("conv_start_single", conv_start, 0);
  endtask

  task automatic consume(input int n_stop, input bit bp);
    int n = 0, t = 0;
    bit stalled = 0;
    logic [DATA_W-1:0] last_d = '0;
    m_ready = 1'b0;
    while (n < n_stop && t < 3000) begin
      @(negedge clk);
      t++;
      if (m_valid) begin
        if (stalled) chk("stall_stable", m_data, last_d);
        chk("m_data", m_data, exp_q[n]);
        chk("m_last", m_last, n == NPIX - 1);
        m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = !m_ready;
        last_d = m_data;
        if (m_ready) n++;
      end else m_ready = 1'b0;
    end
    if (n < n_stop) chk("out_count", n, n_stop);
  endtask

  task automatic end_checks(input bit exp_fr);
    @(negedge clk);
    m_ready = 1'b0;
    chk("end_busy", busy, 0);
    chk("end_m_valid", m_valid, 0);
    chk("end_s_ready", s_ready, 1);
    chk("err_framing", err_framing, exp_fr);
    chk("err_timeout", err_timeout, 0);
  endtask

  initial begin
    bit mv_seen;
    tbl[0] = '{0, 1, 1, 80, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 80, 1, 1, 0, 0};
    tbl[2] = '{0, 1, 1, 40, 0, 0, 0, 1};
    tbl[3] = '{200, 7, 8'h35, 80, 1, 0, 2, 0};
    tbl[4] = '{255, 255, 8'hFF, 81, 1, 1, 0, 1};
    do_reset();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_conv_start", conv_start, 0);
    chk("rst_errs", {err_framing, err_timeout}, 0);
    chk("rst_in_matrix", conv_input_matrix, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_frame(tbl[i].base, tbl[i].step, tbl[i].add);
      core_mode = tbl[i].mode;
      fork
        load_frame(tbl[i].last_at, tbl[i].gaps);
        consume(NPIX, tbl[i].bp);
      join
      end_checks(tbl[i].exp_fr);
    end

    // core never finishes: frame abandoned after TO wait cycles
    do_reset();
    set_frame(0, 1, 1);
    core_mode = 1;
    load_frame(80, 0);
    mv_seen = 0;
    for (int i = 2; i <= TO + 1; i++) begin
      @(negedge clk);
      mv_seen |= m_valid;
      if (i == TO) chk("timeout_not_yet", err_timeout, 0);
    end
    chk("timeout_set", err_timeout, 1);
    chk("timeout_s_ready", s_ready, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_m_valid", mv_seen, 0);

    // reset in the middle of unloading, then a clean frame
    do_reset();
    core_mode = 0;
    set_frame(0, 1, 1);
    fork
      load_frame(80, 0);
      consume(10, 0);
    join
    @(negedge clk);
    m_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_busy", busy, 0);
    set_frame(0, 1, 2);
    fork
      load_frame(80, 0);
      consume(NPIX, 0);
    join
    end_checks(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_stream_adapter.md
Name: conv_stream_adapter

Overview:
Host-side driver for the convolution block. It packs a serial pixel stream into the 9x9 input matrix and pulses start. It waits for done, captures the output matrix, and streams it back out pixel by pixel. This is the initiator end of the start/input_matrix/done/output_matrix interface, placed between the system stream fabric and the convolution core.

Parameters:
DATA_W, 8, pixel width in bits
ROWS, 9, matrix rows
COLS, 9, matrix columns
TIMEOUT_CYCLES, 65535, maximum WAIT cycles before the frame is abandoned
(derived) NPIX = ROWS*COLS = 81; MAT_W = DATA_W*NPIX = 648

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_data  in  DATA_W  input pixel
s_valid  in  1  input pixel valid
s_ready  out  1  adapter accepts a pixel
s_last  in  1  sender marks the final pixel of a frame
conv_start  out  1  one-cycle start pulse to the convolution core
conv_input_matrix  out  MAT_W  packed input matrix, held stable
conv_done  in  1  core completion
conv_output_matrix  in  MAT_W  core result
m_data  out  DATA_W  output pixel
m_valid  out  1  output pixel valid
m_ready  in  1  downstream accepts
m_last  out  1  final output pixel of a frame
busy  out  1  frame in flight
err_framing  out  1  sticky; s_last mismatch
err_timeout  out  1  sticky; core did not finish

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All registered outputs and the matrix registers reset to 0. The state resets to LOAD with pixel index idx=0.
- Packing order is row-major: pixel k = i*COLS+j occupies bits [k*DATA_W +: DATA_W]. The same order applies to both matrices.
- LOAD:
  - s_ready=1.
  - A transfer happens on s_valid&s_ready. It writes s_data into conv_input_matrix slot idx, then idx++.
  - Framing check: s_last=1 on k<NPIX-1, or s_last=0 on k=NPIX-1, sets err_framing. The frame is still counted purely by pixel count.
  - The transfer at idx=NPIX-1 moves to START and sets idx=0.
- START:
  - conv_start=1 for exactly this one cycle; s_ready=0.
  - Next state is WAIT; the wait counter clears.
  - conv_done is ignored in this cycle.
- WAIT:
  - The wait counter increments each cycle.
  - conv_done=1: conv_output_matrix is captured into an internal register, and the state moves to UNLOAD.
  - Counter reaching TIMEOUT_CYCLES without done: err_timeout is set, the frame is dropped, and the state moves to LOAD.
  - If done and timeout occur in the same cycle, done wins.
- UNLOAD:
  - m_valid=1; m_data = captured slot idx; m_last = (idx==NPIX-1).
  - Advance happens on m_valid&m_ready.
  - m_data and m_last are held stable while m_valid&!m_ready.
  - After the last transfer the state moves to LOAD with idx=0.
  - s_ready=0 throughout UNLOAD.
- Latency:
  - Last input accept in cycle N: conv_start=1 in cycle N+1.
  - conv_done seen in WAIT in cycle M: m_valid=1 with pixel 0 in cycle M+1.
  - Output throughput is 1 pixel/cycle when m_ready is held at 1.
- conv_input_matrix holds its last value outside LOAD and is only written by accepted pixels.
- busy = (state!=LOAD) | (idx!=0).
- err_framing and err_timeout are cleared only by rst.
- Reset mid-operation: rst in any state produces LOAD, idx=0, conv_start=0, m_valid=0 and s_ready=1 on the following cycle. The partial frame is discarded.

Decomposition:
- Package conv_pkg holds:
  - DATA_W, ROWS, COLS, NPIX, MAT_W;
  - the state enum {LOAD, START, WAIT, UNLOAD};
  - the counter width, defined as clog2(NPIX).
- One sub-module, conv_pix_counter: a 0..NPIX-1 counter with enable, synchronous clear and an at_last flag. It is shared by LOAD and UNLOAD.

Test Plan:
1. Ramp frame s_data=k for k=0..80, s_last on k=80, m_ready=1. The core model returns input+1 after 20 cycles.
   - conv_input_matrix[k*8+:8]=k.
   - conv_start is a single pulse one cycle after the k=80 accept.
   - Output stream is 1..81 with m_last only on 81.
   - Both error flags remain 0.
2. Random 50% m_ready backpressure, plus random s_valid gaps.
   - Same data and order as scenario 1.
   - m_data is stable under stalls.
   - No pixel is lost or duplicated.
3. Timeout with TIMEOUT_CYCLES=100 and a core model that never asserts done.
   - err_timeout rises 100 cycles into WAIT.
   - The state returns to LOAD with s_ready=1.
   - m_valid is never asserted.
4. Framing error: s_last asserted on pixel 40.
   - err_framing=1.
   - The frame still takes 81 pixels and completes with correct output.
5. Reset mid-UNLOAD after 10 outputs.
   - Next cycle: m_valid=0, s_ready=1, busy=0.
   - A following ramp frame produces the correct full 81-pixel output.
6. conv_done held high during START.
   - Capture happens only from the first WAIT cycle.
   - Output corresponds to the current frame.
